// File: rtl/lzd_norm_pipe.sv
// lzd_norm_pipe: two-stage leading-zero count and normalise pipeline for the adder sum, with full back-pressure
module lzd_norm_pipe #(
  parameter int MANT_W = 25,
  parameter int EXP_W = 8,
  localparam int SH_W = $clog2(MANT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [SH_W-1:0]   nshift,
  output logic              zero,
  output logic              denorm,
  output logic              ovf
);
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  logic              s1_valid, s1_carry, s1_zero;
  logic [MANT_W-1:0] s1_mant;
  logic [EXP_W-1:0]  s1_exp;
  logic [SH_W-1:0]   s1_lz, lz, dsh, n_sh;
  logic [EXP_W:0]    e1;
  logic [EXP_W-1:0]  lze, n_exp;
  logic [MANT_W-1:0] n_mant;
  logic              s2_rdy, n_ovf, n_den;
  assign s2_rdy = !out_valid | out_ready;
  assign in_ready = !rst & (!s1_valid | s2_rdy);
  // the highest set bit below the carry wins because it is visited last
  always_comb begin
    lz = SH_W'(MANT_W-1);
    for (int i = 0; i < MANT_W-1; i++)
      if (mant_in[i]) lz = SH_W'(MANT_W-2-i);
  end
  // exp_in at or above all-ones-minus-one with a carry saturates to infinity, so the exponent never wraps
  always_comb begin
    e1 = {1'b0, s1_exp} + (EXP_W+1)'(1);
    lze = EXP_W'(s1_lz);
    dsh = (s1_exp == '0) ? '0 : SH_W'(s1_exp - EXP_W'(1));
    n_ovf = s1_carry & (e1 >= EMAX);
    n_den = !s1_carry & !s1_zero & (lze >= s1_exp);
    n_sh = (s1_carry | s1_zero) ? '0 : (n_den ? dsh : s1_lz);
    n_mant = (s1_zero | n_ovf) ? '0 : (s1_carry ? s1_mant >> 1 : s1_mant << n_sh);
    n_exp = (s1_zero | n_den) ? '0 : (n_ovf ? '1 : (s1_carry ? e1[EXP_W-1:0] : s1_exp - lze));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_carry <= 1'b0;
      s1_zero <= 1'b0;
      s1_mant <= '0;
      s1_exp <= '0;
      s1_lz <= '0;
      out_valid <= 1'b0;
      mant_out <= '0;
      exp_out <= '0;
      nshift <= '0;
      zero <= 1'b0;
      denorm <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        s1_carry <= mant_in[MANT_W-1];
        s1_zero <= ~|mant_in;
        s1_mant <= mant_in;
        s1_exp <= exp_in;
        s1_lz <= lz;
      end
      if (s2_rdy) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          mant_out <= n_mant;
          exp_out <= n_exp;
          nshift <= n_sh;
          zero <= s1_zero;
          denorm <= n_den;
          ovf <= n_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_lzd_norm_pipe.sv
// tb_lzd_norm_pipe: directed vectors with hand-computed results for lzd_norm_pipe
module tb_lzd_norm_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [24:0] mant_in, mant_out;
  logic [7:0]  exp_in, exp_out;
  logic [4:0]  nshift;
  logic        zero, denorm, ovf;
  int passes = 0, total = 0;
  always #5 clk = ~clk;
  lzd_norm_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mant_in(mant_in), .exp_in(exp_in), .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .exp_out(exp_out), .nshift(nshift),
    .zero(zero), .denorm(denorm), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic chk_out(input string tag, input logic [24:0] m, input logic [7:0] e,
                         input logic [4:0] n, input logic z, input logic d, input logic o);
    chk({tag, ".valid"}, 64'(out_valid), 64'(1));
    chk({tag, ".mant"}, 64'(mant_out), 64'(m));
    chk({tag, ".exp"}, 64'(exp_out), 64'(e));
    chk({tag, ".nshift"}, 64'(nshift), 64'(n));
    chk({tag, ".flags"}, 64'({zero, denorm, ovf}), 64'({z, d, o}));
  endtask
  task automatic drive(input logic v, input logic [24:0] m, input logic [7:0] e);
    in_valid = v;
    mant_in = m;
    exp_in = e;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0);
    repeat (3) tick();
    chk("rst.in_ready", 64'(in_ready), 64'(0));
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.outs", 64'({mant_out, exp_out, nshift, zero, denorm, ovf}), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 64'(in_ready), 64'(1));
    drive(1'b1, 25'h0800000, 8'h80);
    tick();
    drive(1'b0, '0, '0);
    chk("lat.not_yet", 64'(out_valid), 64'(0));
    tick();
    chk_out("normal0", 25'h0800000, 8'h80, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 25'h1800000, 8'h80);
    tick();
    drive(1'b1, 25'h1000000, 8'hFE);
    tick();
    drive(1'b0, '0, '0);
    chk_out("carry", 25'h0C00000, 8'h81, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("ovf", 25'h0000000, 8'hFF, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 25'h0000001, 8'h80);
    tick();
    drive(1'b1, 25'h0000001, 8'h05);
    tick();
    drive(1'b0, '0, '0);
    chk_out("lz23", 25'h0800000, 8'h69, 5'd23, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("denorm", 25'h0000010, 8'h00, 5'd4, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 25'h0000000, 8'h42);
    tick();
    drive(1'b1, 25'h1FFFFFF, 8'h42);
    tick();
    drive(1'b1, 25'h0400000, 8'h01);
    chk_out("zero", 25'h0000000, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0);
    chk_out("all_ones", 25'h0FFFFFF, 8'h43, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("lz_eq_exp", 25'h0400000, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("idle.out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b0;
    drive(1'b1, 25'h0800000, 8'h80);
    #1;
    chk("bp.ready_a", 64'(in_ready), 64'(1));
    tick();
    drive(1'b1, 25'h0400000, 8'h10);
    chk("bp.ready_b", 64'(in_ready), 64'(1));
    tick();
    drive(1'b1, 25'h1800000, 8'h20);
    for (int i = 0; i < 4; i++) begin
      chk("bp.ready_low", 64'(in_ready), 64'(0));
      chk_out("bp.hold", 25'h0800000, 8'h80, 5'd0, 1'b0, 1'b0, 1'b0);
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp.ready_release", 64'(in_ready), 64'(1));
    tick();
    drive(1'b1, 25'h0000100, 8'h03);
    chk_out("bp.b", 25'h0800000, 8'h0F, 5'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0);
    chk_out("bp.c", 25'h0C00000, 8'h21, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("bp.d", 25'h0000400, 8'h00, 5'd2, 1'b0, 1'b1, 1'b0);
    tick();
    chk("bp.drained", 64'(out_valid), 64'(0));
    drive(1'b1, 25'h0800000, 8'h80);
    tick();
    drive(1'b1, 25'h0400000, 8'h10);
    tick();
    drive(1'b0, '0, '0);
    rst = 1'b1;
    #1;
    chk("mrst.in_ready", 64'(in_ready), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("mrst.out_valid", 64'(out_valid), 64'(0));
    chk("mrst.outs", 64'({mant_out, exp_out, nshift, zero, denorm, ovf}), 64'(0));
    chk("mrst.in_ready_after", 64'(in_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst.no_stale", 64'(out_valid), 64'(0));
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/lzd_norm_pipe.md
LZD_NORM_PIPE -- requirements
Module: lzd_norm_pipe

Interface
REQ-001 SHALL have parameter MANT_W, default 25: mantissa width; bit MANT_W-1 is the adder carry-out and bit MANT_W-2 is the hidden-bit position.
REQ-002 SHALL have parameter EXP_W, default 8: biased exponent width.
REQ-003 SHALL have derived localparam SH_W = clog2(MANT_W), which is 5 at the defaults.
REQ-004 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1: input beat valid.
REQ-007 Port in_ready, output, 1: block can accept an input beat.
REQ-008 Port mant_in, input, MANT_W: unnormalised sum from the adder.
REQ-009 Port exp_in, input, EXP_W: exponent before normalisation.
REQ-010 Port out_valid, output, 1: result valid.
REQ-011 Port out_ready, input, 1: downstream accepts the result.
REQ-012 Port mant_out, output, MANT_W: normalised mantissa; bit MANT_W-1 is always 0.
REQ-013 Port exp_out, output, EXP_W: adjusted exponent.
REQ-014 Port nshift, output, SH_W: applied left-shift count; 0 for right-shift and zero cases.
REQ-015 Port zero, output, 1: input mantissa was all zero.
REQ-016 Port denorm, output, 1: shift was clamped by the exponent, so the result is subnormal.
REQ-017 Port ovf, output, 1: exponent overflow on carry right-shift.

Function
REQ-018 SHALL transfer an input beat when in_valid&in_ready, and an output beat when out_valid&out_ready.
REQ-019 SHALL be a 2-stage pipeline.
- S1 registers the inputs, the leading-zero count lz, carry = mant_in[MANT_W-1], and zero.
- S2 registers the shifted mantissa, the exponent and the flags.
REQ-020 Latency SHALL be exactly 2 cycles from the input transfer to out_valid when not stalled; throughput SHALL be 1 beat/cycle.
REQ-021 lz SHALL be the number of zeros from bit MANT_W-2 down to the first 1.
- Range 0..MANT_W-2.
- Value MANT_W-1 when bits MANT_W-2..0 are all zero.
REQ-022 Back-pressure SHALL be full-pipeline.
- Each stage advances only when the next stage is empty or advancing.
- in_ready = !S1_valid | S1_advance.
- No beat is lost or duplicated; order is preserved.
REQ-023 Outputs SHALL hold stable while out_valid&!out_ready.
REQ-024 Carry case (carry=1): mant_out = mant_in>>1; exp_out = exp_in+1; nshift=0.
REQ-025 If exp_in+1 equals all-ones: ovf=1, exp_out = all-ones, mant_out = 0 (infinity encoding).
REQ-026 Normal case (carry=0, !zero, lz < exp_in): mant_out = mant_in<<lz; exp_out = exp_in-lz; nshift=lz.
REQ-027 Denorm case (carry=0, !zero, lz >= exp_in): sh = (exp_in==0) ? 0 : exp_in-1; mant_out = mant_in<<sh; exp_out=0; nshift=sh; denorm=1.
REQ-028 Zero case (mant_in all zero): mant_out=0, exp_out=0, nshift=0, zero=1, other flags 0.
REQ-029 At most one of zero, denorm and ovf SHALL be 1 per beat.
REQ-030 Exponent arithmetic SHALL be unsigned EXP_W bits and SHALL never wrap (guaranteed by REQ-025 and REQ-027).
REQ-031 Simultaneous input transfer and output transfer in the same cycle SHALL both occur.

Reset
REQ-032 While rst=1 at a clock edge: S1_valid=0, S2_valid=0, out_valid=0, in_ready=0.
REQ-033 While rst=1 at a clock edge: mant_out, exp_out and nshift SHALL be 0, and zero, denorm and ovf SHALL be 0.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-035 Reset mid-operation SHALL discard all in-flight beats; no out_valid SHALL be produced for them.

Verification (MANT_W=25, EXP_W=8)
REQ-036 mant_in=0x0800000, exp_in=0x80, out_ready=1 -> 2 cycles later: mant_out=0x0800000, exp_out=0x80, nshift=0, no flags.
REQ-037 mant_in=0x1800000, exp_in=0x80 -> mant_out=0x0C00000, exp_out=0x81; then mant_in=0x1000000, exp_in=0xFE -> exp_out=0xFF, mant_out=0, ovf=1.
REQ-038 mant_in=0x0000001, exp_in=0x80 -> mant_out=0x0800000, exp_out=0x69, nshift=23; then exp_in=0x05 -> mant_out=0x0000010, exp_out=0, nshift=4, denorm=1.
REQ-039 mant_in=0, exp_in=0x42 -> mant_out=0, exp_out=0, zero=1; then all-ones mant_in=0x1FFFFFF -> carry path, mant_out=0x0FFFFFF.
REQ-040 Back-pressure: stream 4 beats with out_ready=0 for 5 cycles.
- in_ready drops after 2 beats are accepted.
- Outputs hold stable while stalled.
- After out_ready=1, all 4 results emerge in order, back-to-back.
REQ-041 Mid-operation reset: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and all outputs 0 the next cycle, no stale result appears afterwards, and in_ready=1 after release.
